seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised multiplexed 7-segment display driver for common-anode displays. It time-multiplexes `DIGITS` hexadecimal digits onto one shared active-low segment bus, with per-digit decimal points, a global blank, and an anti-ghosting guard interval. A load handshake defers new values to frame boundaries, so a displayed frame never mixes old and new digits. It sits between application logic (counters, BCD sources) and the board's anode/segment pins.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 1..16.
- `SCAN_DIV`, 250000: `clk1` cycles per digit slot; must be greater than `GUARD + 1`.
- `GUARD`, 16: cycles at the start of each slot during which all anodes are off.
- `clk1`  in  1: system clock (50 MHz).
- `rst`  in  1: asynchronous, active-high reset.
- `load`  in  1: one-cycle request to capture `value` and `dp`.
- `value`  in  4*DIGITS: hex nibbles; nibble i (`value[4i+3:4i]`) is shown on digit i.
- `dp`  in  DIGITS: decimal-point enables, bit i belongs to digit i; 1 = lit.
- `blank`  in  1: 1 = all anodes off.
- `ready`  out  1: 1 = no pending update.
- `frame_done`  out  1: one-cycle pulse at each frame boundary.
- `an`  out  DIGITS: anode enables, active low.
- `seg`  out  8: `{dp,g,f,e,d,c,b,a}`, active low.

## Operation
- Divider `div` counts 0..SCAN_DIV-1 and wraps. On each wrap, scan index `idx` advances 0..DIGITS-1 and wraps to 0.
- Active digit is `idx`. Driven outputs:
  - `an` = all ones except `an[idx]` = 0.
  - `seg` = decoded nibble `idx` of the display register. Bit 7 = `~dp_reg[idx]`.
- Guard: while `div < GUARD`, `an` = all ones and `seg` = 8'hFF.
- `blank` = 1 forces `an` = all ones. The scan counters keep running.
- Pending register:
  - `load` copies `value`/`dp` into the pending register, sets pending, and drops `ready`.
  - A `load` while pending overwrites the pending data; the latest load wins.
- Frame boundary is the cycle with `div == SCAN_DIV-1` and `idx == DIGITS-1`. On that edge:
  - If pending, the display register takes the pending data and pending clears.
  - `frame_done` pulses.
- `load` on the boundary cycle bypasses the pending register: the display register takes `value`/`dp` directly and pending ends clear.
- Decode: 0-F map to the standard hex glyphs, with lower-case b and d.

## Timing
- `an`, `seg`, `ready` and `frame_done` are all registered. Each reflects the `div`/`idx`/register state of the previous cycle (one-cycle latency).
- Reset values:
  - Outputs: `an` all ones, `seg` 8'hFF, `ready` 1, `frame_done` 0.
  - Internal: `div` 0, `idx` 0, display register 0, dp register 0, pending 0.
- Frame period is DIGITS*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-GUARD cycles per frame.
- `ready` falls the cycle after `load` and rises the cycle after the frame boundary.
- Worst-case load-to-display latency is DIGITS*SCAN_DIV + 1 cycles.
- Reset mid-frame discards pending data and restarts the scan at digit 0 with the guard active.
- Counter widths:
  - `div` is $clog2(SCAN_DIV) bits.
  - `idx` is max(1, $clog2(DIGITS)) bits.
  - Both use explicit compare-and-wrap. There is no reliance on natural overflow.

## Configuration
- `SEG_LZB_EN`: leading-zero blanking.
- Defined:
  - Digit i > 0 has segments a-g forced off when all nibbles at index ≥ i are zero in the display register.
  - Its decimal point is still honoured.
  - Digit 0 is never blanked.
  - The blank mask is computed from the display register, never from the pending data.
- Undefined: every digit decodes normally, including zeros.

## Structure
- Package `seg_pkg`:
  - 7-bit active-low glyph constants `{g..a}`: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
  - `SEG_OFF` = 8'hFF.
- Sub-module `seg_hex_decode`: combinational nibble-to-glyph decoder. It is instantiated once and fed through the `idx` mux.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=8, GUARD=2.
- Reset release, no load: `an` steps 4'b1110, 1101, 1011, 0111 every 8 cycles with 2 guard cycles of 4'b1111. `seg`=8'hC0 (the "0" glyph) on each lit digit. `frame_done` pulses every 32 cycles.
- `load` with `value`=16'h4321, `dp`=4'b0100 mid-frame: `ready`=0 until the boundary. Next frame shows digit 0 `seg`=8'hF9, digit 1 8'hA4, digit 2 8'h30 (dp lit), digit 3 8'h99.
- Two loads in one frame (16'h1111 then 16'hABCD): only 16'hABCD is ever displayed.
- `load` exactly on the boundary cycle with 16'h00F0: it is displayed from the very next slot, and `ready` stays 1.
- `blank`=1 for one full frame: `an` stays 4'b1111 and `frame_done` still pulses on schedule.
- `SEG_LZB_EN` defined with `value`=16'h0050, `dp`=0: digits 3 and 2 are `seg`=8'hFF, digit 1 = 8'h92, digit 0 = 8'hC0. Without the macro, digits 3 and 2 show 8'hC0.

Source files
------------

// File: rtl/seg_scan_mux_pkg.sv
// Shared constants for the multiplexed 7-segment driver: active-low hex
// glyphs {g..a}, the all-off segment pattern and a counter-width helper.
package seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [7:0] SEG_OFF     = 8'hFF;

    // A single-digit build still needs a 1-bit scan index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Application-side bus of the 7-segment scan driver: load handshake,
// digit data, blanking and the registered pin/status outputs.
interface seg_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic                  blank;
    logic                  ready;
    logic                  frame_done;
    logic [DIGITS-1:0]     an;
    logic [7:0]            seg;

    modport master (
        output load, value, dp, blank,
        input  ready, frame_done, an, seg
    );

    modport slave (
        input  load, value, dp, blank,
        output ready, frame_done, an, seg
    );
endinterface

// File: rtl/seg_scan_mux_hex_decode.sv
// Combinational nibble to active-low {g..a} glyph decoder (lower-case b, d).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode 7-segment driver with frame-aligned loads and
// anti-ghosting guard. Optional leading-zero blanking: define SEG_LZB_EN.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 250000,
    parameter int GUARD    = 16
) (
    input  logic           clk1,
    input  logic           rst,
    seg_scan_mux_if.slave  bus
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = idx_width(DIGITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_C  = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]      div;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   disp_val;
    logic [DIGITS-1:0]     disp_dp;
    logic [4*DIGITS-1:0]   pend_val;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pending;
    logic                  pending_nxt;

    logic                  div_wrap;
    logic                  boundary;
    logic [3:0]            nibble;
    logic [6:0]            glyph;
    logic                  lz_blank;

    logic [DIGITS-1:0]     an_q;
    logic [7:0]            seg_q;
    logic                  ready_q;
    logic                  frame_done_q;

    assign div_wrap = (div == DIV_LAST);
    assign boundary = div_wrap && (idx == IDX_LAST);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div_wrap) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_comb begin
        pending_nxt = pending;
        if (boundary)
            pending_nxt = 1'b0;
        else if (bus.load)
            pending_nxt = 1'b1;
    end

    // A load on the boundary goes straight to the display register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pending  <= 1'b0;
        end else begin
            if (boundary) begin
                if (bus.load) begin
                    disp_val <= bus.value;
                    disp_dp  <= bus.dp;
                end else if (pending) begin
                    disp_val <= pend_val;
                    disp_dp  <= pend_dp;
                end
            end else if (bus.load) begin
                pend_val <= bus.value;
                pend_dp  <= bus.dp;
            end
            pending <= pending_nxt;
        end
    end

    assign nibble = disp_val[4*idx +: 4];

    seg_hex_decode u_decode (
        .nibble (nibble),
        .glyph  (glyph)
    );

`ifdef SEG_LZB_EN
    logic [DIGITS-1:0] zero_from;

    // zero_from[i]: every nibble at index i and above is zero.
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (disp_val[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--)
            zero_from[i] = zero_from[i+1] && (disp_val[4*i +: 4] == 4'h0);
    end

    assign lz_blank = (idx != '0) && zero_from[idx];
`else
    assign lz_blank = 1'b0;
`endif

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= boundary;
            ready_q      <= ~pending_nxt;
            if (div < GUARD_C) begin
                an_q  <= '1;
                seg_q <= SEG_OFF;
            end else begin
                an_q  <= bus.blank ? '1 : ~(DIGITS'(1) << idx);
                seg_q <= {~disp_dp[idx], lz_blank ? GLYPH_BLANK : glyph};
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.ready      = ready_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed and random stimulus for seg_scan_mux against a cycle-count
// reference model (DIGITS=4, SCAN_DIV=8, GUARD=2).
module tb_seg_scan_mux;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    seg_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_mux #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .GUARD    (GUARD)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model: cycles since reset release, displayed and pending contents.
    int          k;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp,  p_dp;
    bit          m_pend;

    logic [7:0]  obs_seg [DIGITS];
    int          lit_cnt, fd_cnt, f9_seen;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h k=%0d", tag, obs, exp, k);
        end
    endtask

    function automatic logic [7:0] model_seg(input int div, input int idx);
        logic [3:0] nib;
        bit         lzb;
        if (div < GUARD) return 8'hFF;
        nib = 4'((m_val >> (4 * idx)) & 16'hF);
        lzb = 1'b0;
`ifdef SEG_LZB_EN
        lzb = (idx > 0) && ((m_val >> (4 * idx)) == 16'h0);
`endif
        return {~m_dp[idx], lzb ? 7'h7F : HEX[nib]};
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < DIGITS; i++) obs_seg[i] = 8'h00;
        lit_cnt = 0;
        fd_cnt  = 0;
        f9_seen = 0;
    endtask

    task automatic model_reset();
        k = 0;
        m_val = '0; m_dp = '0; p_val = '0; p_dp = '0; m_pend = 1'b0;
    endtask

    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit bl);
        int         div, idx;
        bit         bnd;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        bus.load  = ld;
        bus.value = v;
        bus.dp    = d;
        bus.blank = bl;
        div = k % SCAN_DIV;
        idx = (k / SCAN_DIV) % DIGITS;
        bnd = ((k % FRAME) == FRAME - 1);
        e_an  = (div < GUARD || bl) ? 4'hF : ~(4'b0001 << idx);
        e_seg = model_seg(div, idx);
        @(posedge clk1);
        #1;
        if (bnd) begin
            if (ld) begin
                m_val = v; m_dp = d;
            end else if (m_pend) begin
                m_val = p_val; m_dp = p_dp;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            p_val = v; p_dp = d; m_pend = 1'b1;
        end
        check("an",         {4'h0, bus.an},           {4'h0, e_an});
        check("seg",        bus.seg,                  e_seg);
        check("frame_done", {7'h0, bus.frame_done},   {7'h0, bnd});
        check("ready",      {7'h0, bus.ready},        {7'h0, !m_pend});
        if (bus.an !== 4'hF) begin
            obs_seg[idx] = bus.seg;
            lit_cnt++;
            if (bus.seg === 8'hF9) f9_seen++;
        end
        if (bus.frame_done === 1'b1) fd_cnt++;
        k++;
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    // Runs up to and through the next boundary cycle.
    task automatic to_boundary();
        while ((k % FRAME) != FRAME - 1) step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    logic [7:0] z_hi;

    initial begin
        bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.blank = 1'b0;
`ifdef SEG_LZB_EN
        z_hi = 8'hFF;
`else
        z_hi = 8'hC0;
`endif
        model_reset();
        clear_obs();
        @(posedge clk1);
        #1;
        check("rst_an",    {4'h0, bus.an},         8'h0F);
        check("rst_seg",   bus.seg,                8'hFF);
        check("rst_ready", {7'h0, bus.ready},      8'h01);
        check("rst_fd",    {7'h0, bus.frame_done}, 8'h00);
        rst = 1'b0;

        // Free-running scan of the reset contents.
        idle(FRAME);
        check("idle_d0", obs_seg[0], 8'hC0);
        check("idle_d1", obs_seg[1], z_hi);
        check("idle_d3", obs_seg[3], z_hi);
        check("idle_lit", 8'(lit_cnt), 8'(DIGITS * (SCAN_DIV - GUARD)));
        check("idle_fd",  8'(fd_cnt), 8'd1);

        // Mid-frame load waits for the boundary.
        idle(5);
        step(1'b1, 16'h4321, 4'b0100, 1'b0);
        check("load_ready_low", {7'h0, bus.ready}, 8'h00);
        to_boundary();
        check("load_ready_high", {7'h0, bus.ready}, 8'h01);
        clear_obs();
        idle(FRAME);
        check("l_d0", obs_seg[0], 8'hF9);
        check("l_d1", obs_seg[1], 8'hA4);
        check("l_d2", obs_seg[2], 8'h30);
        check("l_d3", obs_seg[3], 8'h99);

        // Two loads in one frame: latest wins.
        idle(3);
        step(1'b1, 16'h1111, 4'h0, 1'b0);
        idle(4);
        step(1'b1, 16'hABCD, 4'h0, 1'b0);
        to_boundary();
        clear_obs();
        idle(FRAME);
        check("two_no1", 8'(f9_seen), 8'd0);
        check("two_d0", obs_seg[0], 8'hA1);
        check("two_d1", obs_seg[1], 8'hC6);
        check("two_d2", obs_seg[2], 8'h83);
        check("two_d3", obs_seg[3], 8'h88);

        // Load exactly on the boundary cycle.
        while ((k % FRAME) != FRAME - 1) step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 16'h00F0, 4'h0, 1'b0);
        check("bnd_ready", {7'h0, bus.ready}, 8'h01);
        clear_obs();
        idle(SCAN_DIV);
        check("bnd_d0_first_slot", obs_seg[0], 8'hC0);
        idle(FRAME - SCAN_DIV);
        check("bnd_d1", obs_seg[1], 8'h8E);
        check("bnd_d2", obs_seg[2], z_hi);
        check("bnd_d3", obs_seg[3], z_hi);

        // Blanked frame: anodes dark, frame pulse unaffected.
        clear_obs();
        for (int i = 0; i < FRAME; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
        check("blank_lit", 8'(lit_cnt), 8'd0);
        check("blank_fd",  8'(fd_cnt),  8'd1);

        // Leading-zero case.
        step(1'b1, 16'h0050, 4'h0, 1'b0);
        to_boundary();
        clear_obs();
        idle(FRAME);
        check("lz_d0", obs_seg[0], 8'hC0);
        check("lz_d1", obs_seg[1], 8'h92);
        check("lz_d2", obs_seg[2], z_hi);
        check("lz_d3", obs_seg[3], z_hi);

        // Random loads and blanking.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom),
                 $urandom_range(0, 7) == 0);
        end

        // Reset mid-frame discards the pending load.
        idle(3);
        step(1'b1, 16'h9999, 4'hF, 1'b0);
        idle(2);
        rst = 1'b1;
        #1;
        check("mrst_an",    {4'h0, bus.an},         8'h0F);
        check("mrst_seg",   bus.seg,                8'hFF);
        check("mrst_ready", {7'h0, bus.ready},      8'h01);
        check("mrst_fd",    {7'h0, bus.frame_done}, 8'h00);
        @(posedge clk1);
        #1;
        rst = 1'b0;
        model_reset();
        clear_obs();
        idle(FRAME);
        check("mrst_d0",  obs_seg[0], 8'hC0);
        check("mrst_d2",  obs_seg[2], z_hi);
        check("mrst_fd_cnt", 8'(fd_cnt), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
